sigma_serializer: RTL

Downstream stage of the 16-point accumulator: captures each 12-bit two's-complement sum when its one-cycle sync pulse arrives and sends it out as a self-framed serial word on a single line. The frame is start, 12 data bits LSB first, even parity, stop. A one-deep pending buffer absorbs a result that arrives mid-frame. Overruns are flagged and counted.

---
 rtl/sigma_ser_pkg.sv | 27 ++
 rtl/sigma_serializer_bit_tick.sv | 50 +++++
 rtl/sigma_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sigma_ser_pkg.sv
// -----------------------------------------------------------------------------
// sigma_ser_pkg
// Shared definitions for the sigma serializer: FSM state encoding, frame
// constants and the even-parity helper used when a word is loaded for sending.
// -----------------------------------------------------------------------------
package sigma_ser_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_e;

    localparam int         FRAME_DATA_BITS = 12;
    localparam logic       START_LVL       = 1'b0;
    localparam logic       STOP_LVL        = 1'b1;
    localparam logic [7:0] OVR_MAX         = 8'hFF;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sigma_serializer_bit_tick.sv
// -----------------------------------------------------------------------------
// bit_tick
// Bit-period divider. Counts 0..BIT_DIV-1 and flags the last count of each
// period on tick_o; restart_i holds the count at 0 so the first period after
// restart is a full BIT_DIV clocks long.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   restart_i  synchronous restart, holds the counter at 0
//   tick_o     high during the final clock of each bit period
// -----------------------------------------------------------------------------
module bit_tick #(
    parameter int BIT_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int            CW   = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next divider count: restart and wrap both return to zero
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/sigma_serializer.sv
// -----------------------------------------------------------------------------
// sigma_serializer
// Captures each accumulator result on its sync strobe and sends it as a
// 15-bit frame: start(0), 12 data bits LSB first, even parity, stop(1).
// A one-deep pending buffer holds a result that arrives mid-frame; a second
// arrival overwrites it (newest wins) and is reported as an overrun.
// Ports:
//   clk      system clock (rising edge)
//   res      asynchronous active-low reset
//   data_in  two's-complement result, valid while syn_in = 1
//   syn_in   one-cycle result strobe
//   ser_out  serial line, idles high
//   busy     frame in progress
//   overrun  one-cycle pulse when the pending word is overwritten
//   ovr_cnt  saturating overrun count
// -----------------------------------------------------------------------------
module sigma_serializer
    import sigma_ser_pkg::*;
#(
    parameter int BIT_DIV = 16,
    parameter int DW      = 12
) (
    input  logic          clk,
    input  logic          res,
    input  logic [DW-1:0] data_in,
    input  logic          syn_in,
    output logic          ser_out,
    output logic          busy,
    output logic          overrun,
    output logic [7:0]    ovr_cnt
);

    localparam logic [3:0] LAST_BIT = 4'(DW - 1);

    ser_state_e    state_q;
    logic [DW-1:0] shift_q;
    logic          par_q;
    logic [3:0]    bit_cnt_q;
    logic [DW-1:0] pend_q;
    logic          pend_vld_q;
    logic          ser_q;
    logic          busy_q;
    logic          ovr_q;
    logic [7:0]    ovr_cnt_q;

    logic          tick_s;
    logic          restart_s;
    logic          mid_frame_s;

    // The divider is parked while idle so START always gets a full bit period
    assign restart_s = (state_q == IDLE);

    bit_tick #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_tick (
        .clk_i     (clk),
        .rst_ni    (res),
        .restart_i (restart_s),
        .tick_o    (tick_s)
    );

    // Strobes go to the pending buffer anywhere in a frame except the last
    // STOP clock, where the frame hand-over logic consumes them instead
    assign mid_frame_s = (state_q == START) || (state_q == DATA) ||
                         (state_q == PARITY) || ((state_q == STOP) && !tick_s);

    // Frame sequencer, shift register, pending buffer and overrun counter
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= 4'd0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ser_q      <= STOP_LVL;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ovr_cnt_q  <= 8'h00;
        end else begin
            ovr_q <= 1'b0;

            if (syn_in && mid_frame_s) begin
                pend_q     <= data_in;
                pend_vld_q <= 1'b1;
                if (pend_vld_q) begin
                    ovr_q <= 1'b1;
                    if (ovr_cnt_q != OVR_MAX) begin
                        ovr_cnt_q <= ovr_cnt_q + 8'd1;
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (syn_in) begin
                        shift_q   <= data_in;
                        par_q     <= even_parity(data_in);
                        bit_cnt_q <= 4'd0;
                        ser_q     <= START_LVL;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        ser_q     <= shift_q[0];
                        bit_cnt_q <= 4'd0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            ser_q   <= par_q;
                            state_q <= PARITY;
                        end else begin
                            // shift_q[1] becomes bit 0 after this shift
                            shift_q   <= shift_q >> 1;
                            ser_q     <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        ser_q   <= STOP_LVL;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (pend_vld_q) begin
                            shift_q   <= pend_q;
                            par_q     <= even_parity(pend_q);
                            bit_cnt_q <= 4'd0;
                            ser_q     <= START_LVL;
                            state_q   <= START;
                            // A strobe on this edge refills the buffer
                            // just as it drains, so nothing is lost
                            if (syn_in) begin
                                pend_q <= data_in;
                            end else begin
                                pend_vld_q <= 1'b0;
                            end
                        end else if (syn_in) begin
                            shift_q   <= data_in;
                            par_q     <= even_parity(data_in);
                            bit_cnt_q <= 4'd0;
                            ser_q     <= START_LVL;
                            state_q   <= START;
                        end else begin
                            ser_q   <= STOP_LVL;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    ser_q   <= STOP_LVL;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;
    assign ovr_cnt = ovr_cnt_q;

endmodule
